// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine that owns the HI/LO register pair.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiply; divide stays iterative.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             unsign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   a_orig_reg;
  logic               op_div_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic               div0_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign a_neg = !unsign && a[WIDTH-1];
  assign b_neg = !unsign && b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {add_sum, acc_reg[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
  assign shifted  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign diff     = shifted - {1'b0, opnd_reg};
  assign div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      a_orig_reg  <= '0;
      op_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_div_reg  <= op_div;
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            div0_reg    <= (b == '0);
            a_orig_reg  <= a;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            if (op_div) begin
              acc_reg   <= {{WIDTH{1'b0}}, mag_a};
              opnd_reg  <= mag_b;
              state_reg <= RUN;
            end else begin
`ifdef MULDIV_FAST_MULT_EN
              acc_reg   <= fast_prod;
              state_reg <= FINISH;
`else
              acc_reg   <= {{WIDTH{1'b0}}, mag_b};
              opnd_reg  <= mag_a;
              state_reg <= RUN;
`endif
            end
          end else begin
            if (mthi) hi_reg <= wdata;
            if (mtlo) lo_reg <= wdata;
          end
        end
        RUN: begin
          acc_reg <= op_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= FINISH;
        end
        FINISH: begin
          if (!op_div_reg) begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end else if (div0_reg) begin
            hi_reg <= a_orig_reg;
            lo_reg <= {WIDTH{1'b1}};
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, random ops against
// an arithmetic reference model, and handshake / reset corner sequences.
module tb_hilo_muldiv_unit;

  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = WIDTH + 1;
`endif
  localparam int DIV_LAT = WIDTH + 1;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             op_div;
  logic             unsign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_div(op_div), .unsign(unsign),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        op_div;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference results straight from the arithmetic definition of MULT/DIV.
  function automatic void ref_model(input logic opd, input logic uns,
                                    input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    if (uns) begin
      sa = longint'({32'b0, av});
      sb = longint'({32'b0, bv});
    end else begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
    end
    if (!opd) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else if (bv == 32'd0) begin
      rh = av;
      rl = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rl = 32'(q);
      rh = 32'(r);
    end
  endfunction

  task automatic launch(input logic opd, input logic uns, input logic [31:0] av, input logic [31:0] bv);
    op_div = opd;
    unsign = uns;
    a      = av;
    b      = bv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 45) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic opd, input logic uns,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h0, l0;
    int lat, busy_cnt, exp_lat;
    bit hold_ok;
    h0 = hi;
    l0 = lo;
    exp_lat = opd ? DIV_LAT : MUL_LAT;
    launch(opd, uns, av, bv);
    lat = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    while (!done && lat < 45) begin
      if (busy) busy_cnt++;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      tick();
      lat++;
    end
    $display("op %s div=%0b uns=%0b a=%h b=%h -> hi=%h lo=%h latency=%0d", nm, opd, uns, av, bv, hi, lo, lat);
    check({nm, "_done"}, {31'b0, done}, 32'd1);
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({nm, "_hold"}, {31'b0, hold_ok}, 32'd1);
    check({nm, "_busy_end"}, {31'b0, busy}, 32'd0);
    check({nm, "_hi"}, hi, eh);
    check({nm, "_lo"}, lo, el);
    tick();
    check({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] rh, rl, dh, dl;
    int lat, ndone, first;

    vecs[0]  = '{"umul_max",   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"smul_neg",   1'b0, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{"sdiv_neg",   1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"udiv",       1'b1, 1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{"sdiv_ovf",   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{"sdiv_zero",  1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6]  = '{"udiv_zero",  1'b1, 1'b1, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF};
    vecs[7]  = '{"smul_minsq", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{"sdiv_negb",  1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{"udiv_one",   1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[10] = '{"umul_carry", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};

    reset_n = 1'b0;
    start   = 1'b0;
    op_div  = 1'b0;
    unsign  = 1'b0;
    a       = '0;
    b       = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wdata   = '0;
    repeat (2) tick();
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].name, vecs[i].op_div, vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    for (int i = 0; i < 24; i++) begin
      logic        ropd, runs;
      logic [31:0] ra, rb;
      int          mode;
      ropd = 1'($urandom_range(0, 1));
      runs = 1'($urandom_range(0, 1));
      ra   = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0)      rb = 32'd0;
      else if (mode == 1) rb = 32'($urandom_range(1, 15));
      else if (mode == 2) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else                rb = $urandom;
      ref_model(ropd, runs, ra, rb, rh, rl);
      run_op($sformatf("rand%0d", i), ropd, runs, ra, rb, rh, rl);
    end

    // MTHI/MTLO in idle, both together, and while busy.
    wdata = 32'hAAAA_5555; mthi = 1'b1; tick(); mthi = 1'b0;
    $display("mthi idle wdata=%h -> hi=%h", wdata, hi);
    check("mthi_idle_hi", hi, 32'hAAAA_5555);
    dl = lo;
    check("mthi_idle_lo_kept", lo, dl);
    wdata = 32'h1357_9BDF; mtlo = 1'b1; tick(); mtlo = 1'b0;
    $display("mtlo idle wdata=%h -> lo=%h", wdata, lo);
    check("mtlo_idle_lo", lo, 32'h1357_9BDF);
    check("mtlo_idle_hi_kept", hi, 32'hAAAA_5555);
    wdata = 32'h5A5A_5A5A; mthi = 1'b1; mtlo = 1'b1; tick(); mthi = 1'b0; mtlo = 1'b0;
    $display("mthi+mtlo idle wdata=%h -> hi=%h lo=%h", wdata, hi, lo);
    check("mthilo_hi", hi, 32'h5A5A_5A5A);
    check("mthilo_lo", lo, 32'h5A5A_5A5A);

    launch(1'b1, 1'b1, 32'd100, 32'd7);
    tick(); tick();
    wdata = 32'hAAAA_5555; mthi = 1'b1; tick(); mthi = 1'b0;
    $display("mthi busy wdata=%h -> hi=%h busy=%0b", wdata, hi, busy);
    check("mthi_busy_hi", hi, 32'h5A5A_5A5A);
    wait_done(lat);
    check("mthi_busy_done", {31'b0, done}, 32'd1);
    check("mthi_busy_res_hi", hi, 32'd2);
    check("mthi_busy_res_lo", lo, 32'd14);
    tick();
    wdata = 32'hAAAA_5555; mthi = 1'b1; tick(); mthi = 1'b0;
    $display("mthi after op wdata=%h -> hi=%h", wdata, hi);
    check("mthi_after_hi", hi, 32'hAAAA_5555);
    check("mthi_after_lo", lo, 32'd14);

    // MTHI in the same cycle as an accepted start is dropped.
    wdata = 32'h2222_2222; mthi = 1'b1;
    launch(1'b0, 1'b1, 32'd3, 32'd4);
    mthi = 1'b0;
    $display("mthi with start wdata=%h -> hi=%h", wdata, hi);
    check("mthi_start_hi", hi, 32'hAAAA_5555);
    wait_done(lat);
    check("mthi_start_done", {31'b0, done}, 32'd1);
    check("mthi_start_res_hi", hi, 32'd0);
    check("mthi_start_res_lo", lo, 32'd12);
    tick();

    // Second start during RUN is ignored; exactly one done.
    launch(1'b1, 1'b1, 32'd100, 32'd7);
    ndone = 0;
    first = -1;
    dh = '0;
    dl = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin
        op_div = 1'b0; unsign = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = k;
          dh = hi;
          dl = lo;
        end
      end
    end
    $display("restart-while-busy: dones=%0d first=%0d hi=%h lo=%h", ndone, first, dh, dl);
    check("restart_ndone", 32'(ndone), 32'd1);
    check("restart_latency", 32'(first), 32'(DIV_LAT));
    check("restart_hi", dh, 32'd2);
    check("restart_lo", dl, 32'd14);

    // Reset at cycle 10 of a divide aborts it.
    launch(1'b1, 1'b0, 32'h1234_5678, 32'd3);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    $display("reset mid-op -> hi=%h lo=%h busy=%0b done=%0b", hi, lo, busy, done);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("midrst_no_activity", 32'(ndone), 32'd0);
    check("midrst_hi_kept", hi, 32'd0);
    run_op("after_reset", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle multiply/divide engine plus the architectural HI/LO register pair.
- Sits beside the combinational ALU. Receives MULT/MULTU/DIV/DIVU operands from the register file and owns the HI/LO state.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Replaces the single-cycle 64-bit product/quotient path with an iterative shift-add / restoring-divide datapath and a start/busy/done handshake to the control FSM.

Parameters:
- WIDTH, 32: operand width. HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op_div  input  1  0 = multiply, 1 = divide.
- unsign  input  1  1 = unsigned (MULTU/DIVU), 0 = signed.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on the cycle HI/LO hold a new result.
- hi  output  WIDTH  HI register (remainder / product upper half).
- lo  output  WIDTH  LO register (quotient / product lower half).

Behaviour:
- Reset: clk rising edge with reset_n=0 forces hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset during RUN aborts the operation; no partial result is written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, WIDTH iterations.
  - FINISH: busy=1, sign fix-up and HI/LO write.
- IDLE -> RUN on edge E0 when start=1.
  - Latch |a| and |b| (two's-complement magnitude when unsign=0 and the MSB is set; raw value otherwise).
  - Latch result-sign flags, op_div and unsign.
- RUN: one iteration per cycle. Counter counts 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1-bit partial remainder.
- RUN -> FINISH after WIDTH iterations (edge E32 for WIDTH=32).
- FINISH -> IDLE on edge E33.
  - hi/lo written, busy=0, done=1 for exactly the following cycle.
  - Total latency is WIDTH+1 edges from the start edge.
- Signed multiply: negate the 2*WIDTH product if the sign of a differs from the sign of b.
- Signed divide: quotient truncates toward zero; negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Result: lo=quotient, hi=remainder.
- Divide by zero (b=0, either signedness): hi=a (original value), lo={WIDTH{1'b1}}. Still takes full latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy=1: ignored.
- mthi/mtlo:
  - In IDLE with start=0: write wdata on the next edge. Both asserted writes both registers.
  - While busy=1, or in the same cycle start is accepted: ignored.
- hi/lo are register outputs and hold their value throughout RUN. The new value appears only at FINISH.
- done and mthi never coincide in a way that changes hi: FINISH has priority, because mthi is ignored while busy.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - Multiply uses a single-cycle combinational WIDTH x WIDTH product.
  - IDLE -> FINISH directly, skipping RUN. The product is latched at E0.
  - hi/lo written at E1; done high in the cycle after E1; busy high for one cycle.
  - Divide is unchanged.
- Undefined: multiply is iterative with WIDTH+1 latency, as above.
- The rest of the interface is identical in both builds.

Test Plan:
- Unsigned mult: a=0xFFFFFFFF, b=0xFFFFFFFF, unsign=1, start -> busy for 33 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001. In the FAST build, done one cycle after the write edge.
- Signed mult: a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divides:
  - Signed: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Unsigned: a=100, b=7 -> lo=14, hi=2.
  - Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: a=0x12345678, b=0, unsign=0 -> hi=0x12345678, lo=0xFFFFFFFF after 33 cycles.
- Handshake:
  - Second start at cycle 5 of a RUN -> ignored; one done only.
  - mthi with wdata=0xAAAA5555 during busy -> hi unchanged.
  - Same mthi in IDLE -> hi=0xAAAA5555 next cycle.
- Reset mid-op: reset_n=0 at cycle 10 of a divide -> next edge gives hi=0, lo=0, busy=0, done=0. A new start afterwards completes normally.
